alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU between NREQ requesters (e.g. the integer execute stage and the branch comparator) under round-robin arbitration. Each requester hands over an operation with a valid/ready handshake and receives a registered result and zero flag on its own response channel. The block sits between the issue logic and the ALU, runs one operation at a time through a three-state FSM, and owns all operand/result registering around the ALU.

## Interface
- NREQ, 2: number of requesters (2..4)
- WIDTH, 32: operand/result width; fixed at 32 to match the ALU
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i presents an operation
- req_ready  out  NREQ  operation i accepted this cycle
- req_a  in  NREQ*WIDTH  operand a; requester i at [i*WIDTH +: WIDTH], signed
- req_b  in  NREQ*WIDTH  operand b
- req_op  in  NREQ*3  alu_control code
- resp_valid  out  NREQ  result for requester i available
- resp_ready  in  NREQ  requester i consumes the result
- resp_result  out  WIDTH  result, shared by all responders, qualified by resp_valid
- resp_zero  out  1  zero flag of resp_result
- busy  out  1  FSM not in IDLE

## Operation
- Op codes are passed through unchanged: 000 add, 001 sub, 010 sra (a>>>b), 011 sll, 100 srl, 101 and, 110 xor, 111 add.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 combinationally; every other req_ready bit is 0.
  - On the accept edge, latch a, b, op and gnt_id, then go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - The ALU is driven from the latched operands only.
  - On the edge, capture result and zero into the output registers, then go to RESP.
- RESP:
  - resp_valid[gnt_id]=1; all other bits are 0.
  - Result and zero stay stable until resp_ready[gnt_id]=1.
  - On that edge: rr_ptr <= (gnt_id+1) mod NREQ, then go to IDLE.
- req_ready is 0 in EXEC and RESP. A requester may drop or change req_valid/operands while not accepted, with no side effects.
- Operands are sampled only on the accept edge. Later changes on req_* never affect an accepted operation.
- resp_ready bits of non-granted requesters are ignored.

## Timing
- Reset values: state=IDLE, rr_ptr=0, resp_valid=0, resp_result=0, resp_zero=0, busy=0, latched operands=0. req_ready follows from state=IDLE.
- Accept at edge T, capture at edge T+1, resp_valid high after T+1.
- Response handshake at edge T+2 at the earliest. The next accept can happen in the cycle after that edge.
- Peak throughput is one operation per 3 cycles.
- Simultaneous requests in IDLE: the requester nearest rr_ptr (upward, wrapping) wins. The loser is served next if it is still valid.
- rr_ptr advances only on a response handshake, never on accept alone.
- resp_ready held low: stay in RESP indefinitely. No new accept, and outputs are frozen.
- Async reset mid-EXEC or mid-RESP: the in-flight operation is dropped with no response, and all registers return to their reset values immediately.
- resp_zero is the ALU zero flag (result==0), registered together with the result.

## Structure
- Shared package `alu_pkg`:
  - ALU op-code localparams: ALU_ADD, ALU_SUB, ALU_SRA, ALU_SLL, ALU_SRL, ALU_AND, ALU_XOR.
  - FSM state encoding: ARB_IDLE, ARB_EXEC, ARB_RESP.
- One sub-module instance: the existing `ALU`, fed from the latched a/b/op registers. No other hierarchy.
- The round-robin priority search is a combinational function inside the block.

## Test plan
- **Single request.** req0: a=5, b=3, op=001.
  - req_ready[0] pulses in cycle 0.
  - resp_valid[0] in cycle 2 with result=2, zero=0.
  - With resp_ready[0]=1, busy=0 in cycle 3.
- **Arithmetic shift and zero flag.**
  - req1: a=0x8000_0000, b=4, op=010 -> result 0xF800_0000.
  - Then a=7, b=7, op=110 -> result 0, resp_zero=1.
- **Contention.** Both valid from reset, req0 a=1 b=1 op=000, req1 a=1 b=1 op=011.
  - req0 is served first (result 2).
  - req1 is accepted in the cycle after req0's response handshake (result 2).
  - With both held valid, grants alternate 0,1,0,1.
- **Backpressure.** Hold resp_ready[0]=0 for 10 cycles.
  - resp_valid[0] and resp_result stay stable.
  - req_ready stays 0 while req1 is valid.
  - Releasing resp_ready completes the handshake.
- **Operand stability.** Change req_a right after accept.
  - The response uses the value sampled at accept.
- **Reset mid-operation.** Assert rst_n=0 asynchronously while in EXEC.
  - All outputs drop to 0 at once, with no resp_valid.
  - After release, the first request completes normally with rr_ptr=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the ALU arbiter: op codes and arbiter FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SRA = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters (master) and the ALU arbiter (slave).
interface alu_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [WIDTH-1:0]      resp_result;
  logic                  resp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU; codes 000 and 111 both add.
module ALU
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = a + b;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SRA: result = $signed(a) >>> b;
      ALU_SLL: result = a << b;
      ALU_SRL: result = a >> b;
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, one operation at a time
// through IDLE -> EXEC -> RESP, with all operands and results registered here.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;

  arb_state_t        state, state_next;
  logic [PTR_W-1:0]  rr_ptr, gnt_id, pick_id, next_ptr;
  logic              pick_found;
  logic [PTR_W:0]    pick;
  logic [WIDTH-1:0]  a_q, b_q, sel_a, sel_b, alu_result, result_q;
  logic [2:0]        op_q, sel_op;
  logic              alu_zero, zero_q;
  logic [NREQ-1:0]   req_ready_c, resp_valid_c;

  // Scanning from the far end lets the requester nearest rr_ptr overwrite the rest.
  function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0] found;
    int idx;
    found = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) found = {1'b1, PTR_W'(idx)};
    end
    return found;
  endfunction

  always_comb begin
    pick       = rr_pick(bus.req_valid, rr_ptr);
    pick_found = pick[PTR_W];
    pick_id    = pick[PTR_W-1:0];
    sel_a      = bus.req_a[int'(pick_id)*WIDTH +: WIDTH];
    sel_b      = bus.req_b[int'(pick_id)*WIDTH +: WIDTH];
    sel_op     = bus.req_op[int'(pick_id)*3 +: 3];
    next_ptr   = PTR_W'((int'(gnt_id) + 1) % NREQ);
  end

  always_comb begin
    state_next   = state;
    req_ready_c  = '0;
    resp_valid_c = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          req_ready_c[pick_id] = 1'b1;
          state_next           = ARB_EXEC;
        end
      end
      ARB_EXEC: state_next = ARB_RESP;
      ARB_RESP: begin
        resp_valid_c[gnt_id] = 1'b1;
        if (bus.resp_ready[gnt_id]) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // The pointer moves only on a completed response, so an accept alone never rotates priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      gnt_id   <= '0;
      rr_ptr   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (state == ARB_IDLE && pick_found) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        op_q   <= sel_op;
        gnt_id <= pick_id;
      end
      if (state == ARB_EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
      if (state == ARB_RESP && bus.resp_ready[gnt_id]) rr_ptr <= next_ptr;
    end
  end

  ALU #(.WIDTH(WIDTH)) u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (op_q),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  assign bus.req_ready   = req_ready_c;
  assign bus.resp_valid  = resp_valid_c;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;
  assign busy            = (state != ARB_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;
  int   ptr_model = 0;

  alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'd1:    return a - b;
      3'd2:    return $signed(a) >>> b;
      3'd3:    return a << b;
      3'd4:    return a >> b;
      3'd5:    return a & b;
      3'd6:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic int rr_model(logic [NREQ-1:0] valid, int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx = (ptr + k) % NREQ;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(int i);
    return 32'(1) << i;
  endfunction

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(int i, logic v, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    bus.req_valid[i]          = v;
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_op[i*3 +: 3]      = op;
  endtask

  // Runs one full transaction from IDLE: grant, accept, capture, optional stall, handshake.
  task automatic serve(int stall, bit keep, bit use_exp, logic [31:0] exp_const);
    int id;
    logic [31:0] a, b, exp_res;
    logic [2:0] op;
    #1;
    id = rr_model(bus.req_valid, ptr_model);
    if (id < 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL no_request observed=none expected=valid");
      return;
    end
    a = bus.req_a[id*WIDTH +: WIDTH];
    b = bus.req_b[id*WIDTH +: WIDTH];
    op = bus.req_op[id*3 +: 3];
    exp_res = use_exp ? exp_const : alu_model(a, b, op);
    check_output("grant", 32'(bus.req_ready), onehot(id));
    check_output("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    bus.req_a[id*WIDTH +: WIDTH] = ~a;
    bus.req_b[id*WIDTH +: WIDTH] = b ^ 32'h5;
    if (!keep) bus.req_valid[id] = 1'b0;
    @(negedge clk);
    check_output("exec_busy", 32'(busy), 32'd1);
    check_output("exec_ready", 32'(bus.req_ready), 32'd0);
    check_output("exec_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check_output("resp_valid", 32'(bus.resp_valid), onehot(id));
    check_output("resp_result", bus.resp_result, exp_res);
    check_output("resp_zero", 32'(bus.resp_zero), 32'(exp_res == 32'd0));
    for (int s = 0; s < stall; s++) begin
      bus.resp_ready = ~NREQ'(onehot(id));
      @(posedge clk); @(negedge clk);
      check_output("stall_valid", 32'(bus.resp_valid), onehot(id));
      check_output("stall_result", bus.resp_result, exp_res);
      check_output("stall_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = NREQ'(onehot(id));
    @(posedge clk); #1;
    bus.resp_ready = '0;
    ptr_model = (id + 1) % NREQ;
    @(negedge clk);
    check_output("done_busy", 32'(busy), 32'd0);
    check_output("done_resp_valid", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0] mask;
    logic [31:0] ra, rb;
    logic [2:0] rop;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = '0;
    #2;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("reset_result", bus.resp_result, 32'd0);
    check_output("reset_zero", 32'(bus.resp_zero), 32'd0);
    check_output("reset_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single request and shift/zero cases");
    apply_stimulus(0, 1'b1, 32'd5, 32'd3, 3'b001);
    serve(0, 1'b0, 1'b1, 32'd2);
    apply_stimulus(1, 1'b1, 32'h8000_0000, 32'd4, 3'b010);
    serve(0, 1'b0, 1'b1, 32'hF800_0000);
    apply_stimulus(1, 1'b1, 32'd7, 32'd7, 3'b110);
    serve(0, 1'b0, 1'b1, 32'd0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 24; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < NREQ; i++) begin
        rop = 3'($urandom_range(0, 7));
        ra  = $urandom;
        rb  = (rop inside {3'd2, 3'd3, 3'd4}) ? 32'($urandom_range(0, 31)) : $urandom;
        if ($urandom_range(0, 3) == 0) begin
          rb  = ra;
          rop = 3'b110;
        end
        apply_stimulus(i, mask[i], ra, rb, rop);
      end
      serve($urandom_range(0, 3), 1'b0, 1'b0, 32'd0);
    end
    bus.req_valid = '0;

    $display("[TB] asynchronous reset during EXEC");
    apply_stimulus(0, 1'b1, 32'd10, 32'd20, 3'b000);
    serve(0, 1'b0, 1'b1, 32'd30);
    apply_stimulus(1, 1'b1, 32'd9, 32'd4, 3'b000);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check_output("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("mid_reset_busy", 32'(busy), 32'd0);
    check_output("mid_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("mid_reset_result", bus.resp_result, 32'd0);
    check_output("mid_reset_zero", 32'(bus.resp_zero), 32'd0);
    ptr_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] contention, backpressure and alternation");
    apply_stimulus(0, 1'b1, 32'd1, 32'd1, 3'b000);
    apply_stimulus(1, 1'b1, 32'd1, 32'd1, 3'b011);
    serve(10, 1'b1, 1'b1, 32'd2);
    serve(0, 1'b1, 1'b1, 32'd2);
    for (int it = 0; it < 4; it++) serve(0, 1'b1, 1'b0, 32'd0);
    bus.req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
